// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: request side (from the RTC sequencer), pad side (RTC chip
// pins) and read-back side (to the time/date register file) of rtc_bus_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface rtc_bus_ctrl_if;
    // Sequencer requests
    logic       escritura;
    logic       lectura;
    logic       write;
    logic [7:0] dir;
    logic [3:0] dir_reg;
    logic [7:0] dato;
    // RTC pads
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    // Status and read-back
    logic       fin;
    logic       ocupado;
    logic [7:0] dato_leido;
    logic [3:0] dir_reg_out;
    logic       dato_valido;

    modport slave (
        input  escritura, lectura, write, dir, dir_reg, dato, ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d,
        output fin, ocupado, dato_leido, dir_reg_out, dato_valido
    );

    modport master (
        output escritura, lectura, write, dir, dir_reg, dato, ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d,
        input  fin, ocupado, dato_leido, dir_reg_out, dato_valido
    );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: RTC multiplexed address/data bus stage.
// Turns a level request from the RTC sequencer into one address write cycle
// followed by one data write or data read cycle on the chip pins, then pulses
// fin for one cycle. Read bytes are handed to the register file with their
// slot tag.
//
// All pin outputs are registered from the current state, so the pins lag the
// state register by exactly one cycle; that lag is what makes fin appear
// 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP+1 edges after acceptance, and it keeps the
// pads glitch-free. Every timing parameter must be >= 1.
//
// Optional build macro RTC_IN_SYNC_EN: when defined, ad_in goes through a
// 2-flop synchronizer and the read D_STROBE is stretched by 2 cycles so the
// synchronized byte is sampled while rd_n is still low.
module rtc_bus_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 10,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 4
) (
    input  logic          clk,
    input  logic          reset,
    rtc_bus_ctrl_if.slave bus
);

    localparam int CNT_W = 16;
`ifdef RTC_IN_SYNC_EN
    localparam int RD_EXT = 2;
`else
    localparam int RD_EXT = 0;
`endif

    typedef enum logic [3:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        GAP,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        DONE,
        COOLDOWN
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_zero;
    logic             w_accept;

    // Latched request
    logic [7:0] r_dir;
    logic [7:0] r_dato;
    logic [3:0] r_dir_reg;
    logic       r_write;
    logic       r_kind_rd;

    // Pin values decoded from the current state
    logic       w_cs_n;
    logic       w_rd_n;
    logic       w_wr_n;
    logic       w_a_d;
    logic       w_ad_oe;
    logic [7:0] w_ad_out;
    logic       w_fin;
    logic       w_dato_valido;
    logic       w_last_strobe;

    // Registered pins
    logic       r_cs_n;
    logic       r_rd_n;
    logic       r_wr_n;
    logic       r_a_d;
    logic       r_ad_oe;
    logic [7:0] r_ad_out;
    logic       r_fin;
    logic       r_dato_valido;
    logic       r_ocupado;
    logic       r_last_strobe;
    logic [7:0] r_dato_leido;
    logic [3:0] r_dir_reg_out;

    logic [7:0] w_ad_sample;

    // Number of cycles spent in a state, minus one, as the counter reload value.
    // Only the read D_STROBE is affected by the optional input synchronizer.
    function automatic logic [CNT_W-1:0] f_reload(input state_t s, input logic rd);
        int n;
        case (s)
            A_SETUP, D_SETUP: n = T_SETUP;
            A_STROBE:         n = T_PULSE;
            D_STROBE:         n = rd ? (T_PULSE + RD_EXT) : T_PULSE;
            A_HOLD, D_HOLD:   n = T_HOLD;
            GAP:              n = T_GAP;
            COOLDOWN:         n = 2;
            default:          n = 1;
        endcase
        return CNT_W'(n - 1);
    endfunction

    assign w_cnt_zero = (r_cnt == '0);

`ifdef RTC_IN_SYNC_EN
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    // Two-flop synchronizer on the asynchronous pad input
    always_ff @(posedge clk) begin
        r_sync1 <= bus.ad_in;
        r_sync2 <= r_sync1;
    end

    assign w_ad_sample = r_sync2;
`else
    assign w_ad_sample = bus.ad_in;
`endif

    // Next-state logic: requests are only looked at in IDLE
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.escritura || bus.lectura) begin
                    w_accept     = 1'b1;
                    w_next_state = A_SETUP;
                end
            end
            A_SETUP:  if (w_cnt_zero) w_next_state = A_STROBE;
            A_STROBE: if (w_cnt_zero) w_next_state = A_HOLD;
            A_HOLD:   if (w_cnt_zero) w_next_state = GAP;
            GAP:      if (w_cnt_zero) w_next_state = D_SETUP;
            D_SETUP:  if (w_cnt_zero) w_next_state = D_STROBE;
            D_STROBE: if (w_cnt_zero) w_next_state = D_HOLD;
            D_HOLD:   if (w_cnt_zero) w_next_state = DONE;
            DONE:     if (w_cnt_zero) w_next_state = COOLDOWN;
            COOLDOWN: if (w_cnt_zero) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // State register and single dwell counter, reloaded on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= f_reload(w_next_state, r_kind_rd);
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Request capture at acceptance; escritura wins over lectura
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dir     <= bus.dir;
            r_dato    <= bus.dato;
            r_dir_reg <= bus.dir_reg;
            r_write   <= bus.write;
            r_kind_rd <= !bus.escritura;
        end
    end

    // Pin decode from the current state; strobes are only low inside cs_n low
    always_comb begin
        w_cs_n        = 1'b1;
        w_rd_n        = 1'b1;
        w_wr_n        = 1'b1;
        w_a_d         = 1'b1;
        w_ad_oe       = 1'b0;
        w_ad_out      = 8'h00;
        w_fin         = 1'b0;
        w_dato_valido = 1'b0;
        case (r_state)
            A_SETUP, A_HOLD: begin
                w_cs_n   = 1'b0;
                w_a_d    = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = r_dir;
            end
            A_STROBE: begin
                w_cs_n   = 1'b0;
                w_a_d    = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = r_dir;
                w_wr_n   = 1'b0;
            end
            GAP: begin
                w_a_d = 1'b0;
            end
            D_SETUP, D_HOLD: begin
                w_cs_n   = 1'b0;
                w_ad_oe  = !r_kind_rd;
                w_ad_out = r_kind_rd ? 8'h00 : r_dato;
            end
            D_STROBE: begin
                w_cs_n   = 1'b0;
                w_ad_oe  = !r_kind_rd;
                w_ad_out = r_kind_rd ? 8'h00 : r_dato;
                w_rd_n   = !r_kind_rd;
                w_wr_n   = r_kind_rd;
            end
            DONE: begin
                w_fin         = 1'b1;
                w_dato_valido = r_kind_rd && r_write;
            end
            default: begin
            end
        endcase
    end

    // Last state-cycle of a read strobe; one cycle later it is the last pin
    // cycle with rd_n low, which is where the byte is captured.
    assign w_last_strobe = (r_state == D_STROBE) && w_cnt_zero && r_kind_rd;

    // Registered pad and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cs_n        <= 1'b1;
            r_rd_n        <= 1'b1;
            r_wr_n        <= 1'b1;
            r_a_d         <= 1'b1;
            r_ad_oe       <= 1'b0;
            r_ad_out      <= 8'h00;
            r_fin         <= 1'b0;
            r_dato_valido <= 1'b0;
            r_ocupado     <= 1'b0;
            r_last_strobe <= 1'b0;
        end else begin
            r_cs_n        <= w_cs_n;
            r_rd_n        <= w_rd_n;
            r_wr_n        <= w_wr_n;
            r_a_d         <= w_a_d;
            r_ad_oe       <= w_ad_oe;
            r_ad_out      <= w_ad_out;
            r_fin         <= w_fin;
            r_dato_valido <= w_dato_valido;
            r_ocupado     <= (w_next_state != IDLE);
            r_last_strobe <= w_last_strobe;
        end
    end

    // Read-back byte and its register-file tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dato_leido  <= 8'h00;
            r_dir_reg_out <= 4'h0;
        end else if (r_last_strobe) begin
            r_dato_leido  <= w_ad_sample;
            r_dir_reg_out <= r_dir_reg;
        end
    end

    assign bus.cs_n        = r_cs_n;
    assign bus.rd_n        = r_rd_n;
    assign bus.wr_n        = r_wr_n;
    assign bus.a_d         = r_a_d;
    assign bus.ad_oe       = r_ad_oe;
    assign bus.ad_out      = r_ad_out;
    assign bus.fin         = r_fin;
    assign bus.ocupado     = r_ocupado;
    assign bus.dato_leido  = r_dato_leido;
    assign bus.dir_reg_out = r_dir_reg_out;
    assign bus.dato_valido = r_dato_valido;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: scoreboard bench for rtc_bus_ctrl. The stimulus process
// issues directed transactions and queues the expected outcome; the monitor
// watches the pads every cycle and checks a queued entry on each fin.
module tb_rtc_bus_ctrl;

`ifdef RTC_IN_SYNC_EN
    localparam int RD_LAT = 35;
    localparam int RD_LOW = 12;
`else
    localparam int RD_LAT = 33;
    localparam int RD_LOW = 10;
`endif
    localparam int WR_LAT = 33;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    logic [7:0] rd_val;

    rtc_bus_ctrl_if bus ();

    rtc_bus_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         t_acc;
        int         lat;
        logic       is_rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       dv;
        logic [7:0] rdata;
        logic [3:0] tag;
    } exp_t;

    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // RTC chip model: drives the byte only while it is being read
    initial begin
        bus.ad_in = 8'hEE;
        forever begin
            @(negedge clk);
            bus.ad_in = (!bus.rd_n && !bus.ad_oe) ? rd_val : 8'hEE;
        end
    end

    // Monitor: accumulate pad activity per transaction, check on fin
    initial begin
        int         m_wr_a;
        int         m_wr_d;
        int         m_rd;
        logic [7:0] m_addr;
        logic [7:0] m_wdata;
        logic       m_doe;
        logic       m_glitch;
        exp_t       e;
        m_wr_a = 0; m_wr_d = 0; m_rd = 0; m_addr = 8'h00; m_wdata = 8'h00;
        m_doe = 1'b0; m_glitch = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_wr_a = 0; m_wr_d = 0; m_rd = 0; m_doe = 1'b0; m_glitch = 1'b0;
            end else begin
                if (!bus.cs_n && !bus.a_d && !bus.wr_n) begin
                    m_wr_a = m_wr_a + 1;
                    m_addr = bus.ad_out;
                end
                if (!bus.cs_n && bus.a_d && !bus.wr_n) begin
                    m_wr_d  = m_wr_d + 1;
                    m_wdata = bus.ad_out;
                end
                if (!bus.rd_n) m_rd = m_rd + 1;
                if (!bus.cs_n && bus.a_d && bus.ad_oe) m_doe = 1'b1;
                if ((!bus.rd_n && !bus.wr_n) || (bus.cs_n && (!bus.rd_n || !bus.wr_n)))
                    m_glitch = 1'b1;
                if (bus.dato_valido && !bus.fin) chk("dv_without_fin", 1, 0);
                if (bus.fin) begin
                    if (q.size() == 0) begin
                        chk("unexpected_fin", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("latency", cyc - e.t_acc, e.lat);
                        chk("addr", {24'h0, m_addr}, {24'h0, e.addr});
                        chk("wr_low_addr", m_wr_a, 10);
                        chk("wr_low_data", m_wr_d, e.is_rd ? 0 : 10);
                        chk("rd_low", m_rd, e.is_rd ? RD_LOW : 0);
                        chk("data_oe", {31'h0, m_doe}, {31'h0, !e.is_rd});
                        chk("glitch", {31'h0, m_glitch}, 0);
                        chk("dato_valido", {31'h0, bus.dato_valido}, {31'h0, e.dv});
                        if (e.is_rd) begin
                            chk("dato_leido", {24'h0, bus.dato_leido}, {24'h0, e.rdata});
                            chk("dir_reg_out", {28'h0, bus.dir_reg_out}, {28'h0, e.tag});
                        end else begin
                            chk("wdata", {24'h0, m_wdata}, {24'h0, e.wdata});
                        end
                    end
                    m_wr_a = 0; m_wr_d = 0; m_rd = 0; m_doe = 1'b0; m_glitch = 1'b0;
                end
            end
        end
    end

    task automatic wait_fin();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.fin) return;
        end
        chk("fin_timeout", 0, 1);
    endtask

    // Build and queue the expected outcome of a request about to be accepted
    task automatic push_exp(input logic esc, input logic wr, input logic [7:0] d,
                            input logic [7:0] dt, input logic [3:0] tag,
                            input logic [7:0] rv, input int t_acc);
        exp_t e;
        e.t_acc = t_acc;
        e.is_rd = !esc;
        e.lat   = esc ? WR_LAT : RD_LAT;
        e.addr  = d;
        e.wdata = dt;
        e.dv    = !esc && wr;
        e.rdata = rv;
        e.tag   = tag;
        q.push_back(e);
    endtask

    task automatic do_txn(input logic esc, input logic lec, input logic wr,
                          input logic [7:0] d, input logic [7:0] dt,
                          input logic [3:0] tag, input logic [7:0] rv);
        @(negedge clk);
        bus.escritura = esc;
        bus.lectura   = lec;
        bus.write     = wr;
        bus.dir       = d;
        bus.dato      = dt;
        bus.dir_reg   = tag;
        rd_val        = rv;
        push_exp(esc, wr, d, dt, tag, rv, cyc + 1);
        @(negedge clk);
        chk("ocupado_after_accept", {31'h0, bus.ocupado}, 1);
        bus.escritura = 1'b0;
        bus.lectura   = 1'b0;
        wait_fin();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rd_val = 8'h00;
        bus.escritura = 1'b0;
        bus.lectura   = 1'b0;
        bus.write     = 1'b0;
        bus.dir       = 8'h00;
        bus.dir_reg   = 4'h0;
        bus.dato      = 8'h00;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("reset_pins",
            {19'h0, bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, bus.fin,
             bus.ocupado, bus.dato_valido, 4'h0},
            {19'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        chk("reset_data", {16'h0, bus.ad_out, bus.dato_leido}, 0);
        chk("reset_tag", {28'h0, bus.dir_reg_out}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Plain write, plain read, priority, read without publish, 0x41 read
        do_txn(1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 4'h0, 8'h00);
        do_txn(1'b0, 1'b1, 1'b1, 8'h21, 8'h00, 4'h1, 8'h59);
        do_txn(1'b1, 1'b1, 1'b1, 8'h5A, 8'hA5, 4'h6, 8'h13);
        do_txn(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 4'h7, 8'hC3);
        do_txn(1'b0, 1'b1, 1'b1, 8'h41, 8'h00, 4'h9, 8'h30);

        // Back-to-back reads with lectura held; sequencer steps after fin
        @(negedge clk);
        bus.lectura = 1'b1;
        bus.write   = 1'b1;
        bus.dir     = 8'h21;
        bus.dir_reg = 4'h2;
        rd_val      = 8'h11;
        push_exp(1'b0, 1'b1, 8'h21, 8'h00, 4'h2, 8'h11, cyc + 1);
        wait_fin();
        @(negedge clk);
        bus.dir     = 8'h22;
        bus.dir_reg = 4'h3;
        rd_val      = 8'h22;
        push_exp(1'b0, 1'b1, 8'h22, 8'h00, 4'h3, 8'h22, cyc + 2);
        wait_fin();
        @(negedge clk);
        bus.lectura = 1'b0;
        repeat (6) @(negedge clk);
        chk("ocupado_idle_b2b", {31'h0, bus.ocupado}, 0);

        // Asynchronous reset in the middle of the data strobe
        @(negedge clk);
        bus.lectura = 1'b1;
        bus.write   = 1'b1;
        bus.dir     = 8'h33;
        bus.dir_reg = 4'h5;
        rd_val      = 8'h77;
        push_exp(1'b0, 1'b1, 8'h33, 8'h00, 4'h5, 8'h77, cyc + 1);
        @(negedge clk);
        bus.lectura = 1'b0;
        begin
            int n;
            n = 0;
            while (!(bus.rd_n === 1'b0) && n < 100) begin
                @(negedge clk);
                n = n + 1;
            end
            if (n >= 100) chk("rd_strobe_timeout", 0, 1);
        end
        repeat (3) @(negedge clk);
        q.delete();
        reset = 1'b0;
        #1;
        chk("abort_pins", {27'h0, bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe, bus.fin},
            {27'h0, 5'b11100});
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("ocupado_after_abort", {31'h0, bus.ocupado}, 0);
        do_txn(1'b0, 1'b1, 1'b1, 8'h44, 8'h00, 4'h4, 8'h9E);

        repeat (10) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
- Physical bus stage directly downstream of the RTC read/write sequencer. Converts the sequencer's level requests into multiplexed address/data bus cycles on the RTC chip pins, in the order address write then data write or data read.
- Request inputs: escritura/lectura, dir, dato, write, dir_reg.
- Returns a one-cycle fin pulse per completed transaction and hands read bytes, tagged with dir_reg, to the time/date register file.

Parameters:
T_SETUP, 2, clk cycles cs_n/a_d/ad_out stable before strobe falls (each phase)
T_PULSE, 10, clk cycles rd_n/wr_n held low (each phase)
T_HOLD, 2, clk cycles cs_n/a_d/ad_out held after strobe rises (each phase)
T_GAP, 4, clk cycles cs_n high between address and data phase

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
escritura  in  1  request: write dato to RTC address dir
lectura  in  1  request: read RTC address dir
write  in  1  on read: publish result to register file
dir  in  8  RTC address
dir_reg  in  4  register-file slot tag for read data
dato  in  8  write data
ad_in  in  8  RTC AD bus input (pad side)
ad_out  out  8  RTC AD bus output
ad_oe  out  1  AD bus output enable, 1=drive
cs_n  out  1  RTC chip select, active low
rd_n  out  1  RTC read strobe, active low
wr_n  out  1  RTC write strobe, active low
a_d  out  1  RTC address/data select, 0=address, 1=data
fin  out  1  one-cycle transaction-complete pulse
ocupado  out  1  1 from acceptance until end of COOLDOWN
dato_leido  out  8  last byte read
dir_reg_out  out  4  slot tag of dato_leido
dato_valido  out  1  one-cycle strobe: dato_leido/dir_reg_out valid

Behaviour:
- Reset (reset=0, async): state=IDLE, cs_n=rd_n=wr_n=1, a_d=1, ad_oe=0, ad_out=0, fin=0, ocupado=0, dato_leido=0, dir_reg_out=0, dato_valido=0. Reset mid-transaction aborts at once; no fin is issued.
- Request capture:
  - In IDLE, if escritura|lectura=1 at a rising edge, latch dir, dato, dir_reg, write and kind. Escritura wins if both are high.
  - Inputs are ignored outside IDLE.
- States and transitions:
  - IDLE
  - A_SETUP: cs_n=0, a_d=0, ad_oe=1, ad_out=dir (T_SETUP cycles)
  - A_STROBE: as A_SETUP plus wr_n=0 (T_PULSE)
  - A_HOLD: wr_n=1 (T_HOLD)
  - GAP: cs_n=1, ad_oe=0 (T_GAP)
  - D_SETUP: cs_n=0, a_d=1; write kind: ad_oe=1, ad_out=dato; read kind: ad_oe=0 (T_SETUP)
  - D_STROBE: write kind wr_n=0, read kind rd_n=0 (T_PULSE)
  - D_HOLD (T_HOLD)
  - DONE: all strobes high, cs_n=1, a_d=1, ad_oe=0, fin=1 (1 cycle)
  - COOLDOWN (2 cycles) -> IDLE
- Counter: a single down-counter reloaded on each state entry; the state advances when it reaches 0. Every parameter must be >=1.
- Read sampling: ad_in is registered into dato_leido on the last D_STROBE cycle (rd_n still 0). dir_reg_out is loaded with the latched dir_reg in the same cycle.
- dato_valido=1 in DONE only if kind=read and latched write=1. A read with write=0 updates dato_leido but gives no strobe.
- Latency: fin goes high exactly 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP+1 cycles after the acceptance edge (33 with defaults).
- COOLDOWN reason: the sequencer updates its request outputs one cycle after fin. COOLDOWN guarantees that a stale request (lectura still 1, old dir) is never re-accepted. The earliest next acceptance is 3 edges after the fin cycle.
- Glitch rule: at most one of rd_n/wr_n low at any time. Strobes are never low while cs_n=1.
- ocupado: 1 from the cycle after acceptance through the last COOLDOWN cycle.

Optional Feature:
RTC_IN_SYNC_EN:
- Defined: ad_in passes through a 2-flop synchronizer, and D_STROBE is extended by 2 cycles for read kind only. Sampling uses the synchronized value on the last (extended) D_STROBE cycle. Read latency grows by 2; write latency is unchanged.
- Undefined: ad_in is sampled directly, with no extra cycles.

Test Plan:
- Write: reset released, escritura=1, dir=0xF0, dato=0x00 -> address phase a_d=0, ad_out=0xF0, wr_n low 10 cycles; gap cs_n=1 4 cycles; data phase a_d=1, ad_out=0x00, wr_n low 10 cycles; fin=1 exactly 33 cycles after acceptance; rd_n stays 1.
- Read: lectura=1, write=1, dir=0x21, dir_reg=1, ad_in=0x59 during D_STROBE -> rd_n low 10 cycles, ad_oe=0 in data phase, dato_leido=0x59, dir_reg_out=1, dato_valido=1 coincident with fin.
- Back-to-back reads: lectura held 1 across sequencer steps 0x21 to 0x22 -> exactly one transaction per fin; second address phase drives 0x22, never a repeated 0x21.
- Priority: escritura=lectura=1 -> write transaction, rd_n never low.
- Async reset mid-transaction: reset=0 during D_STROBE -> same cycle cs_n=rd_n=wr_n=1, ad_oe=0, no fin; after release, a new lectura completes normally.
- With RTC_IN_SYNC_EN: read from 0x41, ad_in=0x30 -> dato_leido=0x30, fin at 35 cycles; write latency stays 33.
